branch_redirect_ctrl: RTL

- Sequences front-end redirection after the execute stage resolves a control-transfer instruction.
- Compares the resolved next PC (branch target, or PC+4 when not taken, from the irregular-PC generator) against the PC the front end actually fetched next.
- On mismatch, holds a redirect request to fetch until accepted, then drains wrong-path instructions with a flush window.
- Sits between the EX stage and the IF/ID pipeline registers.

---
 rtl/branch_redirect_ctrl_pkg.sv | 28 ++
 rtl/branch_perf_counter.sv | 39 +++
 rtl/branch_redirect_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/branch_redirect_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : branch_redirect_ctrl_pkg
//  Description : Shared types and constants for the branch redirect controller.
//  Revision    : 1.0
// ============================================================================

`ifndef ENABLE
`define ENABLE 1'b1
`endif
`ifndef DISABLE
`define DISABLE 1'b0
`endif

package branch_redirect_ctrl_pkg;

    localparam int XLEN = 32;
    localparam logic [1:0] ALIGN_MASK = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_DRAIN    = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/branch_perf_counter.sv
`default_nettype none
// ============================================================================
//  Module      : branch_perf_counter
//  Description : Saturating up-counter with a single-cycle increment strobe.
//  Revision    : 1.0
// ============================================================================

module branch_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : branch_redirect_ctrl
//  Description : Compares resolved next PC against the fetched PC, issues a
//                held redirect on mismatch, then flushes the front end.
//                Optional perf counters: BRANCH_REDIRECT_PERF_CNT_EN.
//  Revision    : 1.0
// ============================================================================

module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic [31:0]      ex_irreg_pc,
    input  logic [31:0]      ex_pred_pc,
    output logic             ex_ready,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    input  logic             redirect_ready,
    output logic             flush_front,
    output logic             misalign_trap,
    output logic [31:0]      misalign_addr,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

    state_e          state_q, state_d;
    logic [3:0]      drain_q, drain_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;
    logic            misalign_trap_q, misalign_trap_d;

    logic w_resolve;
    logic w_bad;
    logic w_mis;

    assign ex_ready  = (state_q == ST_IDLE);
    assign w_resolve = ex_ready && ex_valid && ex_is_branch;
    assign w_bad     = (ex_irreg_pc[1:0] != ALIGN_MASK);
    assign w_mis     = (ex_irreg_pc != ex_pred_pc);

    always_comb begin
        state_d         = state_q;
        drain_d         = drain_q;
        redirect_pc_d   = redirect_pc_q;
        misalign_trap_d = `DISABLE;
        misalign_addr_d = misalign_addr_q;
        case (state_q)
            ST_IDLE: begin
                // Misalignment wins over mispredict: the trap unit recovers.
                if (w_resolve && w_bad) begin
                    misalign_trap_d = `ENABLE;
                    misalign_addr_d = ex_irreg_pc;
                end else if (w_resolve && w_mis) begin
                    state_d       = ST_REDIRECT;
                    redirect_pc_d = ex_irreg_pc;
                end
            end
            ST_REDIRECT: begin
                if (redirect_ready) begin
                    state_d = ST_DRAIN;
                    drain_d = FLUSH_INIT;
                end
            end
            ST_DRAIN: begin
                drain_d = drain_q - 4'd1;
                if (drain_q <= 4'd1) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                drain_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            drain_q         <= 4'd0;
            redirect_pc_q   <= '0;
            misalign_trap_q <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            state_q         <= state_d;
            drain_q         <= drain_d;
            redirect_pc_q   <= redirect_pc_d;
            misalign_trap_q <= misalign_trap_d;
            misalign_addr_q <= misalign_addr_d;
        end
    end

    assign redirect_valid = (state_q == ST_REDIRECT);
    assign flush_front    = (state_q != ST_IDLE);
    assign redirect_pc    = redirect_pc_q;
    assign misalign_trap  = misalign_trap_q;
    assign misalign_addr  = misalign_addr_q;

`ifdef BRANCH_REDIRECT_PERF_CNT_EN
    logic w_mispred_evt;
    assign w_mispred_evt = w_resolve && !w_bad && w_mis;

    branch_perf_counter #(.CNT_W(CNT_W)) u_branch_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (w_resolve),
        .count_o (branch_cnt)
    );

    branch_perf_counter #(.CNT_W(CNT_W)) u_mispred_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (w_mispred_evt),
        .count_o (mispred_cnt)
    );
`else
    assign branch_cnt  = '0;
    assign mispred_cnt = '0;
`endif

endmodule

`default_nettype wire
